// File: rtl/fsb_adapter_pkg.sv
// Shared constants, response codes and FSM state type for the multi-channel FSB adapter.
package fsb_adapter_pkg;

   // Register offsets within a channel window, decoded from addr[3:2]
   localparam logic [1:0] OffTxData = 2'd0;  // 0x0
   localparam logic [1:0] OffRxData = 2'd1;  // 0x4
   localparam logic [1:0] OffStatus = 2'd2;  // 0x8
   localparam logic [1:0] OffCtrl   = 2'd3;  // 0xC

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StWack,
      StWresp,
      StRack,
      StRresp
   } fsm_state_e;

   // Number of 32-bit MMIO words needed to carry one FSB packet
   function automatic int unsigned words_per_pkt(input int unsigned width);
      return (width + 32'd31) / 32'd32;
   endfunction

endpackage

// File: rtl/axil_fsb_mc_adapter_if.sv
// AXI4-Lite slave-side bus bundle for the FSB adapter (host is master).
interface axil_fsb_mc_adapter_if;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_awaddr;
   logic        s_wvalid;
   logic        s_wready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_bvalid;
   logic [1:0]  s_bresp;
   logic        s_bready;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_araddr;
   logic        s_rvalid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rready;

   modport master (
      output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
             s_arvalid, s_araddr, s_rready,
      input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
   );

   modport slave (
      input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
             s_arvalid, s_araddr, s_rready,
      output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
   );
endinterface

// File: rtl/fsb_adapter_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear that beats push/pop.
module fsb_adapter_fifo #(
   parameter int unsigned WIDTH = 80,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             pipe_rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (clr) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage write; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wptr_q] <= push_data;
   end

   assign head  = mem_q[rptr_q];
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/axil_fsb_mc_adapter.sv
// AXI4-Lite MMIO bridge to NUM_CH FSB channels with per-channel TX/RX queues and loopback.
module axil_fsb_mc_adapter
   import fsb_adapter_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FSB_WIDTH  = 80,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          pipe_rst_n,
   axil_fsb_mc_adapter_if.slave          bus,
   output logic [NUM_CH-1:0]             fsb_tx_v_o,
   output logic [NUM_CH*FSB_WIDTH-1:0]   fsb_tx_data_o,
   input  logic [NUM_CH-1:0]             fsb_tx_ready_i,
   input  logic [NUM_CH-1:0]             fsb_rx_v_i,
   input  logic [NUM_CH*FSB_WIDTH-1:0]   fsb_rx_data_i,
   output logic [NUM_CH-1:0]             fsb_rx_ready_o
);

   localparam int unsigned W   = words_per_pkt(FSB_WIDTH);
   localparam int unsigned PW  = W * 32;
   localparam int unsigned LW  = FSB_WIDTH - (W - 1) * 32;  // width of the last, truncated word
   localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned IW  = (W > 1) ? $clog2(W) : 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

   fsm_state_e state_q, state_d;

   logic [NUM_CH-1:0][IW-1:0] k_q, k_d, j_q, j_d;
   logic [NUM_CH-1:0][PW-1:0] asm_q, asm_d;
   logic [NUM_CH-1:0]         loop_q, loop_d, clr_q, clr_d;
   logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      rx_en_q;

   logic [NUM_CH-1:0] tx_push, tx_pop, tx_full, tx_empty;
   logic [NUM_CH-1:0] rx_push, rx_pop, rx_full, rx_empty;
   logic [NUM_CH-1:0][FSB_WIDTH-1:0] tx_head, rx_head, rx_push_data;
   logic [NUM_CH-1:0][CW-1:0]        tx_cnt, rx_cnt;
   logic [FSB_WIDTH-1:0]             tx_push_data;
   logic [FSB_WIDTH-1:0]             pkt;
   logic [PW-1:0]                    rx_pad;

   logic [CHW-1:0] wr_ch, rd_ch;
   logic [1:0]     wr_off, rd_off;
   logic           wr_ok, rd_ok;
   logic           unused_bits;

   assign wr_ch  = bus.s_awaddr[4 +: CHW];
   assign rd_ch  = bus.s_araddr[4 +: CHW];
   assign wr_off = bus.s_awaddr[3:2];
   assign rd_off = bus.s_araddr[3:2];
   assign wr_ok  = (bus.s_awaddr[31:4] < 28'(NUM_CH));
   assign rd_ok  = (bus.s_araddr[31:4] < 28'(NUM_CH));

   assign unused_bits = ^{bus.s_wstrb, bus.s_awaddr[1:0], bus.s_araddr[1:0]};

   assign bus.s_awready = (state_q == StWack);
   assign bus.s_wready  = (state_q == StWack);
   assign bus.s_bvalid  = (state_q == StWresp);
   assign bus.s_arready = (state_q == StRack);
   assign bus.s_rvalid  = (state_q == StRresp);
   assign bus.s_bresp   = bresp_q;
   assign bus.s_rresp   = rresp_q;
   assign bus.s_rdata   = rdata_q;

   // Transaction FSM: one outstanding access, write wins over a simultaneous read
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.s_awvalid && bus.s_wvalid) state_d = StWack;
            else if (bus.s_arvalid)            state_d = StRack;
         end
         StWack:  state_d = StWresp;
         StWresp: if (bus.s_bready) state_d = StIdle;
         StRack:  state_d = StRresp;
         StRresp: if (bus.s_rready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Register side effects, packet assembly and RX word readout
   always_comb begin
      k_d     = k_q;
      j_d     = j_q;
      asm_d   = asm_q;
      loop_d  = loop_q;
      clr_d   = '0;
      bresp_d = bresp_q;
      rresp_d = rresp_q;
      rdata_d = rdata_q;
      tx_push = '0;
      rx_pop  = '0;

      pkt = asm_q[wr_ch][FSB_WIDTH-1:0];
      pkt[(W-1)*32 +: LW] = bus.s_wdata[LW-1:0];
      tx_push_data = pkt;
      rx_pad = PW'(rx_head[rd_ch]);

      if (state_q == StWack) begin
         bresp_d = RespOkay;
         if (!wr_ok) begin
            bresp_d = RespSlvErr;
         end else begin
            case (wr_off)
               OffTxData: begin
                  if (k_q[wr_ch] != IW'(W - 1)) begin
                     asm_d[wr_ch][int'(k_q[wr_ch]) * 32 +: 32] = bus.s_wdata;
                     k_d[wr_ch] = k_q[wr_ch] + IW'(1);
                  end else if (!tx_full[wr_ch]) begin
                     tx_push[wr_ch] = 1'b1;
                     k_d[wr_ch]     = '0;
                  end else begin
                     // Final word dropped; k stays put so the host can retry it
                     bresp_d = RespSlvErr;
                  end
               end
               OffCtrl: begin
                  loop_d[wr_ch] = bus.s_wdata[0];
                  clr_d[wr_ch]  = bus.s_wdata[1];
               end
               default: ;
            endcase
         end
      end

      if (state_q == StRack) begin
         rresp_d = RespOkay;
         rdata_d = '0;
         if (!rd_ok) begin
            rresp_d = RespSlvErr;
         end else begin
            case (rd_off)
               OffRxData: begin
                  if (rx_empty[rd_ch]) begin
                     rresp_d = RespSlvErr;
                  end else begin
                     rdata_d = rx_pad[int'(j_q[rd_ch]) * 32 +: 32];
                     if (j_q[rd_ch] == IW'(W - 1)) begin
                        rx_pop[rd_ch] = 1'b1;
                        j_d[rd_ch]    = '0;
                     end else begin
                        j_d[rd_ch] = j_q[rd_ch] + IW'(1);
                     end
                  end
               end
               OffStatus: rdata_d = {16'(rx_cnt[rd_ch]),
                                     16'(FIFO_DEPTH) - 16'(tx_cnt[rd_ch])};
               OffCtrl:   rdata_d = {31'd0, loop_q[rd_ch]};
               default: ;
            endcase
         end
      end

      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (clr_q[c]) begin
            k_d[c] = '0;
            j_d[c] = '0;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) state_q <= StIdle;
      else             state_q <= state_d;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         k_q     <= '0;
         j_q     <= '0;
         asm_q   <= '0;
         loop_q  <= '0;
         clr_q   <= '0;
         bresp_q <= RespOkay;
         rresp_q <= RespOkay;
         rdata_q <= '0;
         rx_en_q <= 1'b0;
      end else begin
         k_q     <= k_d;
         j_q     <= j_d;
         asm_q   <= asm_d;
         loop_q  <= loop_d;
         clr_q   <= clr_d;
         bresp_q <= bresp_d;
         rresp_q <= rresp_d;
         rdata_q <= rdata_d;
         rx_en_q <= 1'b1;  // keeps rx_ready low while reset is asserted
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign tx_pop[c]       = ~tx_empty[c] & (loop_q[c] ? ~rx_full[c] : fsb_tx_ready_i[c]);
      assign rx_push[c]      = loop_q[c] ? (~tx_empty[c] & ~rx_full[c])
                                         : (fsb_rx_v_i[c] & fsb_rx_ready_o[c]);
      assign rx_push_data[c] = loop_q[c] ? tx_head[c] : fsb_rx_data_i[c*FSB_WIDTH +: FSB_WIDTH];
      assign fsb_tx_v_o[c]     = ~tx_empty[c] & ~loop_q[c];
      assign fsb_rx_ready_o[c] = rx_en_q & ~rx_full[c] & ~loop_q[c];
      assign fsb_tx_data_o[c*FSB_WIDTH +: FSB_WIDTH] = tx_head[c];

      fsb_adapter_fifo #(
         .WIDTH (FSB_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_tx_fifo (
         .clk        (clk),
         .pipe_rst_n (pipe_rst_n),
         .clr        (clr_q[c]),
         .push       (tx_push[c]),
         .push_data  (tx_push_data),
         .pop        (tx_pop[c]),
         .head       (tx_head[c]),
         .full       (tx_full[c]),
         .empty      (tx_empty[c]),
         .count      (tx_cnt[c])
      );

      fsb_adapter_fifo #(
         .WIDTH (FSB_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_rx_fifo (
         .clk        (clk),
         .pipe_rst_n (pipe_rst_n),
         .clr        (clr_q[c]),
         .push       (rx_push[c]),
         .push_data  (rx_push_data[c]),
         .pop        (rx_pop[c]),
         .head       (rx_head[c]),
         .full       (rx_full[c]),
         .empty      (rx_empty[c]),
         .count      (rx_cnt[c])
      );
   end

endmodule

// File: tb/tb_axil_fsb_mc_adapter.sv
// Directed self-checking bench for axil_fsb_mc_adapter (4 channels, 80-bit packets, depth 16).
module tb_axil_fsb_mc_adapter;

   localparam int unsigned NUM_CH     = 4;
   localparam int unsigned FSB_WIDTH  = 80;
   localparam int unsigned FIFO_DEPTH = 16;

   logic clk = 1'b0;
   logic pipe_rst_n = 1'b0;
   always #5 clk = ~clk;

   axil_fsb_mc_adapter_if bus();

   logic [NUM_CH-1:0]           fsb_tx_v_o, fsb_tx_ready_i, fsb_rx_v_i, fsb_rx_ready_o;
   logic [NUM_CH*FSB_WIDTH-1:0] fsb_tx_data_o, fsb_rx_data_i;

   axil_fsb_mc_adapter #(
      .NUM_CH     (NUM_CH),
      .FSB_WIDTH  (FSB_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .pipe_rst_n     (pipe_rst_n),
      .bus            (bus),
      .fsb_tx_v_o     (fsb_tx_v_o),
      .fsb_tx_data_o  (fsb_tx_data_o),
      .fsb_tx_ready_i (fsb_tx_ready_i),
      .fsb_rx_v_i     (fsb_rx_v_i),
      .fsb_rx_data_i  (fsb_rx_data_i),
      .fsb_rx_ready_o (fsb_rx_ready_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            output logic [1:0] resp);
      int cnt;
      @(posedge clk); #1;
      bus.s_awaddr  = addr;
      bus.s_wdata   = data;
      bus.s_wstrb   = 4'hF;
      bus.s_awvalid = 1'b1;
      bus.s_wvalid  = 1'b1;
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!bus.s_awready && cnt < 50);
      if (!bus.s_awready) check_val("aw_timeout", 0, 1);
      @(posedge clk); #1;
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      bus.s_bready  = 1'b1;
      cnt = 0;
      while (!bus.s_bvalid && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (!bus.s_bvalid) check_val("b_timeout", 0, 1);
      resp = bus.s_bresp;
      @(posedge clk); #1;
      bus.s_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int cnt;
      @(posedge clk); #1;
      bus.s_araddr  = addr;
      bus.s_arvalid = 1'b1;
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!bus.s_arready && cnt < 50);
      if (!bus.s_arready) check_val("ar_timeout", 0, 1);
      @(posedge clk); #1;
      bus.s_arvalid = 1'b0;
      bus.s_rready  = 1'b1;
      cnt = 0;
      while (!bus.s_rvalid && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (!bus.s_rvalid) check_val("r_timeout", 0, 1);
      data = bus.s_rdata;
      resp = bus.s_rresp;
      @(posedge clk); #1;
      bus.s_rready = 1'b0;
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] exp_resp);
      logic [1:0] resp;
      axi_write(addr, data, resp);
      check_val(tag, resp, exp_resp);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
      logic [31:0] data;
      logic [1:0]  resp;
      axi_read(addr, data, resp);
      check_val({tag, "_data"}, data, exp_data);
      check_val({tag, "_resp"}, resp, exp_resp);
   endtask

   // Fully unchecked write for bulk filling
   task automatic wr_quiet(input logic [31:0] addr, input logic [31:0] data);
      logic [1:0] resp;
      axi_write(addr, data, resp);
   endtask

   logic [79:0] exp_pkt [17];
   int          n_out;
   int          b_cyc, ar_cyc;
   logic        aw_hs, ar_hs, got_r;
   logic [1:0]  bresp_v, rresp_v;
   logic [31:0] rdata_v;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.s_awvalid = 1'b0; bus.s_awaddr = '0; bus.s_wvalid = 1'b0; bus.s_wdata = '0;
      bus.s_wstrb = '0; bus.s_bready = 1'b0; bus.s_arvalid = 1'b0; bus.s_araddr = '0;
      bus.s_rready = 1'b0;
      fsb_tx_ready_i = '0;
      fsb_rx_v_i     = '0;
      fsb_rx_data_i  = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_tx_v", fsb_tx_v_o, 4'h0);
      check_val("rst_rx_ready", fsb_rx_ready_o, 4'h0);
      check_val("rst_valids", {bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_arready,
                               bus.s_rvalid}, 5'b0);
      check_val("rst_resp_data", {bus.s_bresp, bus.s_rresp, bus.s_rdata}, 36'h0);
      pipe_rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("rx_ready_after_rst", fsb_rx_ready_o, 4'hF);

      // 1. Reset mid-write aborts the transaction
      bus.s_awaddr = 32'h000; bus.s_wdata = 32'hCAFE_0001;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      @(posedge clk); #1;
      check_val("t1_in_wack", bus.s_awready, 1'b1);
      pipe_rst_n = 1'b0;
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("t1_no_bvalid_rst", bus.s_bvalid, 1'b0);
      end
      pipe_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("t1_no_bvalid_post", bus.s_bvalid, 1'b0);
      end
      bus.s_bready = 1'b0;
      rd_chk("t1_status", 32'h008, 32'h0000_0010, 2'b00);

      // 2. Three-word packet on channel 1
      wr_chk("t2_w0", 32'h010, 32'h1111_1111, 2'b00);
      wr_chk("t2_w1", 32'h010, 32'h2222_2222, 2'b00);
      check_val("t2_v_partial", fsb_tx_v_o[1], 1'b0);
      wr_chk("t2_w2", 32'h010, 32'h0000_3333, 2'b00);
      check_val("t2_v", fsb_tx_v_o[1], 1'b1);
      check_val("t2_data", fsb_tx_data_o[159:80], 80'h3333_22222222_11111111);
      fsb_tx_ready_i[1] = 1'b1;
      @(posedge clk); #1;
      fsb_tx_ready_i[1] = 1'b0;
      check_val("t2_drained", fsb_tx_v_o[1], 1'b0);

      // 3. Channel 0 fill to full, overflow, drain in order, retry
      for (int p = 0; p < 17; p++) begin
         logic [31:0] w2;
         w2 = 32'hEEEE_3000 + p;
         exp_pkt[p] = {w2[15:0], 32'h2000_0000 + p, 32'h1000_0000 + p};
         wr_quiet(32'h000, 32'h1000_0000 + p);
         wr_quiet(32'h000, 32'h2000_0000 + p);
         if (p < 16) wr_chk("t3_push", 32'h000, w2, 2'b00);
         else        wr_chk("t3_overflow", 32'h000, w2, 2'b10);
      end
      rd_chk("t3_status_full", 32'h008, 32'h0000_0000, 2'b00);
      fsb_tx_ready_i[0] = 1'b1;
      n_out = 0;
      for (int cyc = 0; cyc < 40 && n_out < 16; cyc++) begin
         if (fsb_tx_v_o[0]) begin
            check_val("t3_drain_pkt", fsb_tx_data_o[79:0], exp_pkt[n_out]);
            n_out++;
         end
         @(posedge clk); #1;
      end
      check_val("t3_drain_count", n_out, 16);
      check_val("t3_empty", fsb_tx_v_o[0], 1'b0);
      wr_chk("t3_retry", 32'h000, 32'hEEEE_3010, 2'b00);
      rd_chk("t3_status_after", 32'h008, 32'h0000_0010, 2'b00);

      // 4. Channel 2 loopback
      wr_chk("t4_ctrl", 32'h02C, 32'h0000_0001, 2'b00);
      rd_chk("t4_ctrl_rd", 32'h02C, 32'h0000_0001, 2'b00);
      wr_chk("t4_w0", 32'h020, 32'hAAAA_0001, 2'b00);
      wr_chk("t4_w1", 32'h020, 32'hBBBB_0002, 2'b00);
      wr_chk("t4_w2", 32'h020, 32'hDDDD_CCCC, 2'b00);
      check_val("t4_no_tx_v", fsb_tx_v_o[2], 1'b0);
      rd_chk("t4_status1", 32'h028, 32'h0001_0010, 2'b00);
      rd_chk("t4_r0", 32'h024, 32'hAAAA_0001, 2'b00);
      rd_chk("t4_r1", 32'h024, 32'hBBBB_0002, 2'b00);
      rd_chk("t4_status_mid", 32'h028, 32'h0001_0010, 2'b00);
      rd_chk("t4_r2", 32'h024, 32'h0000_CCCC, 2'b00);
      rd_chk("t4_status0", 32'h028, 32'h0000_0010, 2'b00);
      rd_chk("t4_r_empty", 32'h024, 32'h0000_0000, 2'b10);
      wr_chk("t4_ctrl_off", 32'h02C, 32'h0000_0000, 2'b00);

      // Inbound FSB packet on channel 1
      check_val("rx1_ready", fsb_rx_ready_o[1], 1'b1);
      fsb_rx_data_i[159:80] = 80'h5555_44444444_33333333;
      fsb_rx_v_i[1] = 1'b1;
      @(posedge clk); #1;
      fsb_rx_v_i[1] = 1'b0;
      rd_chk("rx1_r0", 32'h014, 32'h3333_3333, 2'b00);
      rd_chk("rx1_r1", 32'h014, 32'h4444_4444, 2'b00);
      rd_chk("rx1_r2", 32'h014, 32'h0000_5555, 2'b00);

      // 5. Simultaneous write and read: write completes first
      @(posedge clk); #1;
      bus.s_awaddr = 32'h00C; bus.s_wdata = 32'h0000_0001; bus.s_araddr = 32'h00C;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
      bus.s_bready = 1'b1; bus.s_rready = 1'b1;
      b_cyc = -1; ar_cyc = -1; aw_hs = 1'b0; ar_hs = 1'b0; got_r = 1'b0;
      bresp_v = 2'b11; rresp_v = 2'b11; rdata_v = '1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (aw_hs) begin
            bus.s_awvalid = 1'b0;
            bus.s_wvalid  = 1'b0;
         end
         if (ar_hs) bus.s_arvalid = 1'b0;
         aw_hs = bus.s_awready;
         ar_hs = bus.s_arready;
         if (bus.s_bvalid && b_cyc < 0) begin
            b_cyc = i;
            bresp_v = bus.s_bresp;
         end
         if (bus.s_arready && ar_cyc < 0) ar_cyc = i;
         if (bus.s_rvalid && !got_r) begin
            got_r = 1'b1;
            rresp_v = bus.s_rresp;
            rdata_v = bus.s_rdata;
         end
      end
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
      bus.s_bready = 1'b0; bus.s_rready = 1'b0;
      check_val("t5_b_seen", b_cyc >= 0, 1'b1);
      check_val("t5_b_before_ar", ar_cyc > b_cyc, 1'b1);
      check_val("t5_b_latency", b_cyc, 1);
      check_val("t5_bresp", bresp_v, 2'b00);
      check_val("t5_r_seen", got_r, 1'b1);
      check_val("t5_rresp", rresp_v, 2'b00);
      check_val("t5_rdata", rdata_v, 32'h0000_0001);
      wr_chk("t5_ctrl_off", 32'h00C, 32'h0000_0000, 2'b00);

      // 6. Out-of-range channel, then soft-clear on channel 3
      wr_chk("t6_oor_wr", 32'h040, 32'h1234_5678, 2'b10);
      rd_chk("t6_oor_rd", 32'h040, 32'h0000_0000, 2'b10);
      wr_chk("t6_ro_wr", 32'h038, 32'hFFFF_FFFF, 2'b00);
      rd_chk("t6_tx_rd", 32'h030, 32'h0000_0000, 2'b00);
      wr_quiet(32'h030, 32'hDEAD_0000);
      wr_quiet(32'h030, 32'hDEAD_0001);
      wr_chk("t6_clear", 32'h03C, 32'h0000_0002, 2'b00);
      rd_chk("t6_ctrl_rd", 32'h03C, 32'h0000_0000, 2'b00);
      wr_quiet(32'h030, 32'h0123_4567);
      wr_quiet(32'h030, 32'h89AB_CDEF);
      check_val("t6_v_partial", fsb_tx_v_o[3], 1'b0);
      wr_chk("t6_w2", 32'h030, 32'h0000_4567, 2'b00);
      check_val("t6_v", fsb_tx_v_o[3], 1'b1);
      check_val("t6_data", fsb_tx_data_o[319:240], 80'h4567_89ABCDEF_01234567);
      rd_chk("t6_status", 32'h038, 32'h0000_000F, 2'b00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
